fb_write_arbiter: RTL and testbench

Write-port controller for the dual-port frame buffer RAM. Shares the RAM's single write port between three requesters: the camera capture stream, a host register-write path, and an internal clear engine that fills the whole frame with a constant colour. Fixed priority: camera > host > clear. The read port (VGA side) is untouched.

---
 rtl/fb_write_arbiter_pkg.sv | 21 ++
 rtl/fb_write_arbiter_if.sv | 47 ++++
 rtl/fb_write_arbiter_clear_seq.sv | 60 ++++++
 rtl/fb_write_arbiter.sv | 114 +++++++++++
 tb/tb_fb_write_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_write_arbiter_pkg.sv
// Shared types for the frame buffer write-port arbiter: grant codes, clear
// sequencer states and default geometry of the 160x120 frame buffer.
package fb_write_arbiter_pkg;

    localparam int AW_DEFAULT      = 15;
    localparam int DW_DEFAULT      = 16;
    localparam int FB_SIZE_DEFAULT = 19200;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_CAM  = 2'd1,
        G_HOST = 2'd2,
        G_CLR  = 2'd3
    } grant_t;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_RUN  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester and RAM write-port signals of the frame buffer arbiter.
// Handshake: cam_we is a one-cycle push with no backpressure; host_req holds
// addr/data stable until the one-cycle host_ack pulse, which marks the issued
// (or range-suppressed) write; clr_start is a request honoured only while idle.
interface fb_write_arbiter_if
    import fb_write_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
);
    logic          cam_we;
    logic [AW-1:0] cam_addr;
    logic [DW-1:0] cam_data;
    logic          host_req;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data;
    logic          host_ack;
    logic          clr_start;
    logic [DW-1:0] clr_data;
    logic          clr_busy;
    logic          clr_done;
    logic          err_oor;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;
    grant_t        grant;
    clr_state_t    clr_state;

    modport master (
        output cam_we, cam_addr, cam_data,
        output host_req, host_addr, host_data,
        output clr_start, clr_data,
        input  host_ack, clr_busy, clr_done, err_oor,
        input  addr_in, data_in, regwrite,
        input  grant, clr_state
    );

    modport slave (
        input  cam_we, cam_addr, cam_data,
        input  host_req, host_addr, host_data,
        input  clr_start, clr_data,
        output host_ack, clr_busy, clr_done, err_oor,
        output addr_in, data_in, regwrite,
        output grant, clr_state
    );

endinterface

// File: rtl/fb_write_arbiter_clear_seq.sv
// Clear sequencer (fb_clear_seq): walks addresses 0..FB_SIZE-1 with a latched
// colour, advancing only on cycles where the arbiter grants it the write port.
module fb_write_arbiter_clear_seq
    import fb_write_arbiter_pkg::*;
#(
    parameter int AW      = AW_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int FB_SIZE = FB_SIZE_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] fill,
    input  logic          granted,
    output logic          busy,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] colour,
    output logic          last,
    output clr_state_t    state
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FB_SIZE - 1);

    logic [AW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= C_IDLE;
            cnt    <= '0;
            colour <= '0;
        end else begin
            case (state)
                C_IDLE: begin
                    if (start) begin
                        state  <= C_RUN;
                        cnt    <= '0;
                        colour <= fill;
                    end
                end
                C_RUN: begin
                    // Stop on the last address instead of incrementing, so the
                    // counter never runs past the frame or wraps.
                    if (granted) begin
                        if (cnt == LAST_ADDR) begin
                            state <= C_IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= C_IDLE;
            endcase
        end
    end

    assign busy = (state == C_RUN);
    assign addr = cnt;
    assign last = busy && (cnt == LAST_ADDR);

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame buffer write-port arbiter: fixed priority camera > host > clear, with
// one registered cycle between grant decision and the RAM write strobe.
module fb_write_arbiter
    import fb_write_arbiter_pkg::*;
#(
    parameter int AW      = AW_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int FB_SIZE = FB_SIZE_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    fb_write_arbiter_if.slave bus
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FB_SIZE - 1);

    grant_t        grant;
    logic          clr_busy;
    logic          clr_last;
    logic [AW-1:0] clr_addr;
    logic [DW-1:0] clr_colour;
    clr_state_t    clr_state;

    logic          regwrite;
    logic          host_ack;
    logic          clr_done;
    logic          err_oor;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;

    // host_ack blocks the host for one cycle so a request still held during
    // its ack cycle is not written a second time.
    always_comb begin
        grant = G_NONE;
        if (bus.cam_we)
            grant = G_CAM;
        else if (bus.host_req && !host_ack)
            grant = G_HOST;
        else if (clr_busy)
            grant = G_CLR;
    end

    fb_write_arbiter_clear_seq #(
        .AW      (AW),
        .DW      (DW),
        .FB_SIZE (FB_SIZE)
    ) u_clear_seq (
        .clk     (clk),
        .rst     (rst),
        .start   (bus.clr_start),
        .fill    (bus.clr_data),
        .granted (grant == G_CLR),
        .busy    (clr_busy),
        .addr    (clr_addr),
        .colour  (clr_colour),
        .last    (clr_last),
        .state   (clr_state)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            regwrite <= 1'b0;
            host_ack <= 1'b0;
            clr_done <= 1'b0;
            err_oor  <= 1'b0;
            addr_in  <= '0;
            data_in  <= '0;
        end else begin
            regwrite <= 1'b0;
            host_ack <= 1'b0;
            clr_done <= 1'b0;
            err_oor  <= 1'b0;
            case (grant)
                G_CAM: begin
                    if (bus.cam_addr > LAST_ADDR) begin
                        err_oor <= 1'b1;
                    end else begin
                        regwrite <= 1'b1;
                        addr_in  <= bus.cam_addr;
                        data_in  <= bus.cam_data;
                    end
                end
                G_HOST: begin
                    // Acked even when suppressed so the host never stalls.
                    host_ack <= 1'b1;
                    if (bus.host_addr > LAST_ADDR) begin
                        err_oor <= 1'b1;
                    end else begin
                        regwrite <= 1'b1;
                        addr_in  <= bus.host_addr;
                        data_in  <= bus.host_data;
                    end
                end
                G_CLR: begin
                    regwrite <= 1'b1;
                    addr_in  <= clr_addr;
                    data_in  <= clr_colour;
                    clr_done <= clr_last;
                end
                default: ;
            endcase
        end
    end

    assign bus.regwrite  = regwrite;
    assign bus.host_ack  = host_ack;
    assign bus.clr_done  = clr_done;
    assign bus.err_oor   = err_oor;
    assign bus.addr_in   = addr_in;
    assign bus.data_in   = data_in;
    assign bus.clr_busy  = clr_busy;
    assign bus.grant     = grant;
    assign bus.clr_state = clr_state;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: reset, camera burst, host arbitration,
// range errors, reset mid-clear and a full clear with camera interference.
module tb_fb_write_arbiter;
    import fb_write_arbiter_pkg::*;

    localparam int FB = 19200;

    logic clk;
    logic rst;

    fb_write_arbiter_if #(.AW(15), .DW(16)) bus ();

    fb_write_arbiter #(.AW(15), .DW(16), .FB_SIZE(FB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [15:0] mem  [0:FB-1];
    int          wcnt [0:FB-1];

    // RAM model: captures whatever the DUT strobes into the write port.
    always @(negedge clk) begin
        if (bus.regwrite) begin
            mem[bus.addr_in]  = bus.data_in;
            wcnt[bus.addr_in] = wcnt[bus.addr_in] + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cam_we    = 1'b0;
        bus.cam_addr  = '0;
        bus.cam_data  = '0;
        bus.host_req  = 1'b0;
        bus.host_addr = '0;
        bus.host_data = '0;
        bus.clr_start = 1'b0;
        bus.clr_data  = '0;
    endtask

    function automatic logic [15:0] exp_word(input int a);
        case (a)
            5:       return 16'hC002;
            900:     return 16'hC003;
            4000:    return 16'hC004;
            14000:   return 16'hC006;
            100:     return 16'hC007;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int exp_cnt(input int a);
        case (a)
            80, 19199, 5, 900, 4000, 18000, 14000, 100: return 2;
            default: return 1;
        endcase
    endfunction

    initial begin
        int bad;
        int done_cyc;
        int gaps;
        logic [14:0] first_addr;
        logic [14:0] done_addr;
        logic [15:0] done_data;
        logic        busy_at_done;
        logic [14:0] h_addr [3];
        logic [15:0] h_data [3];

        idle_inputs();
        for (int a = 0; a < FB; a++) begin
            mem[a]  = 16'hFFFF;
            wcnt[a] = 0;
        end

        // ---- reset ----
        rst = 1'b0;
        tick();
        tick();
        chk("rst_regwrite", 32'(bus.regwrite), 0);
        chk("rst_host_ack", 32'(bus.host_ack), 0);
        chk("rst_clr_busy", 32'(bus.clr_busy), 0);
        chk("rst_clr_done", 32'(bus.clr_done), 0);
        chk("rst_err_oor",  32'(bus.err_oor), 0);
        chk("rst_addr_in",  32'(bus.addr_in), 0);
        chk("rst_data_in",  32'(bus.data_in), 0);
        rst = 1'b1;
        tick();
        chk("idle_regwrite", 32'(bus.regwrite), 0);

        // ---- camera burst ----
        for (int i = 0; i < 10; i++) begin
            bus.cam_we   = 1'b1;
            bus.cam_addr = 15'(i);
            bus.cam_data = 16'hA5A0 + 16'(i);
            tick();
            chk("cam_regwrite", 32'(bus.regwrite), 1);
            chk("cam_addr",     32'(bus.addr_in), i);
            chk("cam_data",     32'(bus.data_in), 32'hA5A0 + i);
        end
        bus.cam_we = 1'b0;
        tick();
        chk("cam_end_regwrite", 32'(bus.regwrite), 0);
        bad = 0;
        for (int i = 0; i < 10; i++)
            if (mem[i] !== 16'hA5A0 + 16'(i)) bad++;
        chk("cam_readback", 32'(bad), 0);

        // ---- host blocked by camera ----
        bus.host_req  = 1'b1;
        bus.host_addr = 15'h0100;
        bus.host_data = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            bus.cam_we   = 1'b1;
            bus.cam_addr = 15'h0020 + 15'(i);
            bus.cam_data = 16'hB000 + 16'(i);
            tick();
            chk("hc_ack_low",  32'(bus.host_ack), 0);
            chk("hc_cam_addr", 32'(bus.addr_in), 32'h20 + i);
        end
        bus.cam_we = 1'b0;
        tick();
        chk("hc_ack",      32'(bus.host_ack), 1);
        chk("hc_regwrite", 32'(bus.regwrite), 1);
        chk("hc_addr",     32'(bus.addr_in), 32'h0100);
        chk("hc_data",     32'(bus.data_in), 32'h1234);
        bus.host_req = 1'b0;
        tick();
        chk("hc_ack_drop", 32'(bus.host_ack), 0);
        chk("hc_no_write", 32'(bus.regwrite), 0);

        // ---- host back-to-back ----
        h_addr[0] = 15'h0200; h_data[0] = 16'h1111;
        h_addr[1] = 15'h0201; h_data[1] = 16'h2222;
        h_addr[2] = 15'h0202; h_data[2] = 16'h3333;
        for (int w = 0; w < 3; w++) begin
            bus.host_req  = 1'b1;
            bus.host_addr = h_addr[w];
            bus.host_data = h_data[w];
            tick();
            chk("hb_ack",  32'(bus.host_ack), 1);
            chk("hb_addr", 32'(bus.addr_in), 32'(h_addr[w]));
            chk("hb_data", 32'(bus.data_in), 32'(h_data[w]));
            if (w == 2) bus.host_req = 1'b0;
            tick();
            chk("hb_gap_ack",   32'(bus.host_ack), 0);
            chk("hb_gap_write", 32'(bus.regwrite), 0);
        end
        bad = 0;
        for (int w = 0; w < 3; w++)
            if (wcnt[h_addr[w]] != 1 || mem[h_addr[w]] !== h_data[w]) bad++;
        chk("hb_single_writes", 32'(bad), 0);

        // ---- out of range ----
        bus.cam_we   = 1'b1;
        bus.cam_addr = 15'd19200;
        bus.cam_data = 16'hDEAD;
        tick();
        chk("oor_cam_err",   32'(bus.err_oor), 1);
        chk("oor_cam_write", 32'(bus.regwrite), 0);
        bus.cam_we    = 1'b0;
        bus.host_req  = 1'b1;
        bus.host_addr = 15'h7FFF;
        bus.host_data = 16'hBEEF;
        tick();
        chk("oor_host_err",   32'(bus.err_oor), 1);
        chk("oor_host_ack",   32'(bus.host_ack), 1);
        chk("oor_host_write", 32'(bus.regwrite), 0);
        bus.host_req = 1'b0;
        tick();
        chk("oor_err_drop", 32'(bus.err_oor), 0);

        // ---- reset mid-clear ----
        bus.clr_start = 1'b1;
        bus.clr_data  = 16'h5555;
        tick();
        chk("rc_busy",        32'(bus.clr_busy), 1);
        chk("rc_state",       32'(bus.clr_state), 32'(C_RUN));
        chk("rc_first_quiet", 32'(bus.regwrite), 0);
        bus.clr_start = 1'b0;
        tick();
        chk("rc_first_addr", 32'(bus.addr_in), 0);
        chk("rc_first_data", 32'(bus.data_in), 32'h5555);
        for (int i = 0; i < 100; i++) tick();
        chk("rc_addr_100", 32'(bus.addr_in), 100);
        rst = 1'b0;
        tick();
        chk("rc_rst_regwrite", 32'(bus.regwrite), 0);
        chk("rc_rst_busy",     32'(bus.clr_busy), 0);
        chk("rc_rst_done",     32'(bus.clr_done), 0);
        chk("rc_rst_addr",     32'(bus.addr_in), 0);
        chk("rc_rst_data",     32'(bus.data_in), 0);
        rst = 1'b1;
        tick();
        tick();
        chk("rc_no_done", 32'(bus.clr_done), 0);
        chk("rc_idle",    32'(bus.clr_busy), 0);

        // ---- full clear with camera interference ----
        for (int a = 0; a < FB; a++) begin
            mem[a]  = 16'hFFFF;
            wcnt[a] = 0;
        end
        bus.clr_start = 1'b1;
        bus.clr_data  = 16'h0000;
        bus.cam_we    = 1'b1;
        bus.cam_addr  = 15'd80;
        bus.cam_data  = 16'hC000;
        tick();
        chk("cl_start_cam_write", 32'(bus.regwrite), 1);
        chk("cl_start_cam_addr",  32'(bus.addr_in), 80);
        chk("cl_start_busy",      32'(bus.clr_busy), 1);

        done_cyc   = 0;
        gaps       = 0;
        first_addr = 15'h7FFF;
        done_addr  = '0;
        done_data  = 16'hFFFF;
        busy_at_done = 1'b1;
        for (int k = 1; k <= 20000; k++) begin
            bus.cam_we    = 1'b0;
            bus.clr_start = 1'b0;
            bus.clr_data  = 16'h0000;
            case (k)
                10:    begin bus.cam_we = 1'b1; bus.cam_addr = 15'd19199; bus.cam_data = 16'hC001; end
                500:   begin bus.cam_we = 1'b1; bus.cam_addr = 15'd5;     bus.cam_data = 16'hC002; end
                1000:  begin bus.cam_we = 1'b1; bus.cam_addr = 15'd900;   bus.cam_data = 16'hC003; end
                3000:  begin bus.clr_start = 1'b1; bus.clr_data = 16'h7777; end
                5000:  begin bus.cam_we = 1'b1; bus.cam_addr = 15'd4000;  bus.cam_data = 16'hC004; end
                9000:  begin bus.cam_we = 1'b1; bus.cam_addr = 15'd18000; bus.cam_data = 16'hC005; end
                15000: begin bus.cam_we = 1'b1; bus.cam_addr = 15'd14000; bus.cam_data = 16'hC006; end
                19000: begin bus.cam_we = 1'b1; bus.cam_addr = 15'd100;   bus.cam_data = 16'hC007; end
                default: ;
            endcase
            tick();
            if (k == 1) first_addr = bus.addr_in;
            if (!bus.regwrite) gaps++;
            if (bus.clr_done) begin
                done_cyc     = k;
                done_addr    = bus.addr_in;
                done_data    = bus.data_in;
                busy_at_done = bus.clr_busy;
                break;
            end
        end
        bus.clr_data = 16'h0000;
        chk("cl_restart_addr0", 32'(first_addr), 0);
        chk("cl_done_cycles",   32'(done_cyc), 19207);
        chk("cl_done_addr",     32'(done_addr), 19199);
        chk("cl_done_data",     32'(done_data), 0);
        chk("cl_busy_falls",    32'(busy_at_done), 0);
        chk("cl_no_gaps",       32'(gaps), 0);
        tick();
        chk("cl_done_pulse", 32'(bus.clr_done), 0);
        chk("cl_idle_quiet", 32'(bus.regwrite), 0);

        bad = 0;
        for (int a = 0; a < FB; a++)
            if (mem[a] !== exp_word(a)) bad++;
        chk("cl_ram_contents", 32'(bad), 0);
        bad = 0;
        for (int a = 0; a < FB; a++)
            if (wcnt[a] != exp_cnt(a)) bad++;
        chk("cl_write_counts", 32'(bad), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
